pzcorebus_upsizer_wdata_packer: RTL and testbench

//  Write-data packing stage of the corebus upsizer, upstream of the wide (master-side) bus.
//  - Gathers narrow write-data beats from the slave side.
//  - Places each beat at its unit position inside a wide word.
//  - Emits one wide beat, with per-unit enables, when the word is complete or the burst ends.
//  - Counterpart of the upsizer response splitter: that block slices wide responses into narrow beats.

---
 rtl/pzcorebus_upsizer_wdata_packer_if.sv | 51 +++++
 rtl/pzcorebus_upsizer_wdata_packer.sv | 98 +++++++++
 tb/tb_pzcorebus_upsizer_wdata_packer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pzcorebus_upsizer_wdata_packer_if.sv
// Narrow-in / wide-out write-data bus of the upsizer packer.
// slave: packer view; master: view of the block driving narrow beats and accepting wide beats.
interface pzcorebus_upsizer_wdata_packer_if #(
    parameter int unsigned UNIT_WIDTH        = 8,
    parameter int unsigned SLAVE_DATA_WIDTH  = 32,
    parameter int unsigned MASTER_DATA_WIDTH = 128
) ();
    localparam int unsigned SSIZE = SLAVE_DATA_WIDTH / UNIT_WIDTH;
    localparam int unsigned MSIZE = MASTER_DATA_WIDTH / UNIT_WIDTH;
    localparam int unsigned IW    = $clog2(MSIZE);

    logic [IW-1:0]                i_start_index;
    logic                         i_mdata_valid;
    logic                         o_mdata_accept;
    logic [SLAVE_DATA_WIDTH-1:0]  i_mdata;
    logic [SSIZE-1:0]             i_mdata_byteen;
    logic                         i_mdata_last;
    logic                         o_mdata_valid;
    logic                         i_mdata_accept;
    logic [MASTER_DATA_WIDTH-1:0] o_mdata;
    logic [MSIZE-1:0]             o_mdata_byteen;
    logic                         o_mdata_last;

    modport slave (
        input  i_start_index,
        input  i_mdata_valid,
        output o_mdata_accept,
        input  i_mdata,
        input  i_mdata_byteen,
        input  i_mdata_last,
        output o_mdata_valid,
        input  i_mdata_accept,
        output o_mdata,
        output o_mdata_byteen,
        output o_mdata_last
    );

    modport master (
        output i_start_index,
        output i_mdata_valid,
        input  o_mdata_accept,
        output i_mdata,
        output i_mdata_byteen,
        output i_mdata_last,
        input  o_mdata_valid,
        output i_mdata_accept,
        input  o_mdata,
        input  o_mdata_byteen,
        input  o_mdata_last
    );
endinterface

// File: rtl/pzcorebus_upsizer_wdata_packer.sv
// Packs narrow write-data beats into wide beats with per-unit enables.
// Optional PZCOREBUS_UPSIZER_PACKER_ZERO_FILL_EN zeroes output units whose enable is clear.
module pzcorebus_upsizer_wdata_packer #(
    parameter int unsigned UNIT_WIDTH        = 8,
    parameter int unsigned SLAVE_DATA_WIDTH  = 32,
    parameter int unsigned MASTER_DATA_WIDTH = 128
) (
    input logic                           i_clk,
    input logic                           i_rst_n,
    pzcorebus_upsizer_wdata_packer_if.slave bus
);
    localparam int unsigned SSIZE = SLAVE_DATA_WIDTH / UNIT_WIDTH;
    localparam int unsigned MSIZE = MASTER_DATA_WIDTH / UNIT_WIDTH;
    localparam int unsigned IW    = $clog2(MSIZE);

    // First-beat offset is aligned down to a whole narrow beat.
    localparam logic [IW-1:0] START_MASK = ~IW'(SSIZE - 1);
    localparam logic [IW-1:0] LAST_SLOT  = IW'(MSIZE - SSIZE);

    logic                         busy_q;
    logic [IW-1:0]                index_q;
    logic [MASTER_DATA_WIDTH-1:0] acc_data_q;
    logic [MSIZE-1:0]             acc_be_q;
    logic                         out_valid_q;
    logic                         out_last_q;
    logic [MASTER_DATA_WIDTH-1:0] out_data_q;
    logic [MSIZE-1:0]             out_be_q;

    logic                         in_xfer;
    logic                         out_xfer;
    logic                         flush;
    logic [IW-1:0]                idx;
    logic [IW-1:0]                index_next;
    logic [MASTER_DATA_WIDTH-1:0] merged_data;
    logic [MSIZE-1:0]             merged_be;
    logic [MASTER_DATA_WIDTH-1:0] load_data;

    assign bus.o_mdata_accept = !out_valid_q || bus.i_mdata_accept;
    assign bus.o_mdata_valid  = out_valid_q;
    assign bus.o_mdata_last   = out_last_q;
    assign bus.o_mdata        = out_data_q;
    assign bus.o_mdata_byteen = out_be_q;

    assign in_xfer    = bus.i_mdata_valid && bus.o_mdata_accept;
    assign out_xfer   = out_valid_q && bus.i_mdata_accept;
    assign idx        = busy_q ? index_q : (bus.i_start_index & START_MASK);
    assign index_next = idx + IW'(SSIZE);
    assign flush      = in_xfer && ((idx == LAST_SLOT) || bus.i_mdata_last);

    always_comb begin
        merged_data = acc_data_q;
        merged_be   = acc_be_q;
        merged_data[int'(idx)*UNIT_WIDTH +: SLAVE_DATA_WIDTH] = bus.i_mdata;
        merged_be[int'(idx) +: SSIZE] = bus.i_mdata_byteen;
    end

`ifdef PZCOREBUS_UPSIZER_PACKER_ZERO_FILL_EN
    always_comb begin
        load_data = merged_data;
        for (int u = 0; u < int'(MSIZE); u++) begin
            if (!merged_be[u]) begin
                load_data[u*UNIT_WIDTH +: UNIT_WIDTH] = '0;
            end
        end
    end
`else
    assign load_data = merged_data;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q      <= 1'b0;
            index_q     <= '0;
            acc_data_q  <= '0;
            acc_be_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_be_q    <= '0;
        end else begin
            if (in_xfer) begin
                busy_q     <= !bus.i_mdata_last;
                index_q    <= index_next;
                acc_data_q <= flush ? '0 : merged_data;
                acc_be_q   <= flush ? '0 : merged_be;
            end
            // A new word may load in the same cycle the previous one is accepted.
            if (flush) begin
                out_valid_q <= 1'b1;
                out_last_q  <= bus.i_mdata_last;
                out_data_q  <= load_data;
                out_be_q    <= merged_be;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pzcorebus_upsizer_wdata_packer.sv
// Bench for pzcorebus_upsizer_wdata_packer: directed cases plus randomized bursts
// checked against a unit-level packing model; honours PZCOREBUS_UPSIZER_PACKER_ZERO_FILL_EN.
module tb_pzcorebus_upsizer_wdata_packer;
    localparam int unsigned UW    = 8;
    localparam int unsigned SDW   = 32;
    localparam int unsigned MDW   = 128;
    localparam int unsigned SSIZE = SDW / UW;
    localparam int unsigned MSIZE = MDW / UW;
    localparam int unsigned IW    = $clog2(MSIZE);

    typedef struct {
        logic [MDW-1:0]   data;
        logic [MSIZE-1:0] be;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   bp_mode = 0;

    exp_t exp_q[$];
    logic [MDW-1:0]   m_data;
    logic [MSIZE-1:0] m_be;
    bit               m_busy;
    int               m_pos;
    logic [SDW-1:0]   beat_data[16];

    logic             hold;
    logic [MDW-1:0]   h_data;
    logic [MSIZE-1:0] h_be;
    logic             h_last;

    pzcorebus_upsizer_wdata_packer_if #(
        .UNIT_WIDTH       (UW),
        .SLAVE_DATA_WIDTH (SDW),
        .MASTER_DATA_WIDTH(MDW)
    ) bus ();

    pzcorebus_upsizer_wdata_packer #(
        .UNIT_WIDTH       (UW),
        .SLAVE_DATA_WIDTH (SDW),
        .MASTER_DATA_WIDTH(MDW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [MDW-1:0] got, input logic [MDW-1:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [MDW-1:0] unit_mask(input logic [MSIZE-1:0] be);
        logic [MDW-1:0] m;
        m = '0;
        for (int u = 0; u < int'(MSIZE); u++) m[u*UW +: UW] = {UW{be[u]}};
        return m;
    endfunction

    // Place the beat at its slot; a word leaves when the top slot fills or the burst ends.
    task automatic model_beat(input int start, input logic [SDW-1:0] d, input logic [SSIZE-1:0] be,
                              input logic last);
        exp_t e;
        if (!m_busy) m_pos = (start / int'(SSIZE)) * int'(SSIZE);
        for (int u = 0; u < int'(SSIZE); u++) begin
            m_data[(m_pos + u)*UW +: UW] = d[u*UW +: UW];
            m_be[m_pos + u] = be[u];
        end
        if (m_pos == int'(MSIZE - SSIZE) || last) begin
            e.data = m_data;
            e.be   = m_be;
            e.last = last;
            exp_q.push_back(e);
            m_data = '0;
            m_be   = '0;
        end
        m_pos  = (m_pos + int'(SSIZE)) % int'(MSIZE);
        m_busy = !last;
    endtask

    // be_mode: 0 random, 1 all ones, 2 all zeros
    task automatic send_burst(input logic [IW-1:0] start, input int n, input int be_mode,
                              input bit term, output int cycles);
        bit got;
        int guard;
        cycles = 0;
        for (int k = 0; k < n; k++) begin
            bus.i_start_index  = (k == 0) ? start : IW'($urandom);
            bus.i_mdata        = $urandom;
            bus.i_mdata_byteen = (be_mode == 1) ? '1 : (be_mode == 2) ? '0 : SSIZE'($urandom);
            bus.i_mdata_last   = term && (k == n - 1);
            bus.i_mdata_valid  = 1'b1;
            beat_data[k]       = bus.i_mdata;
            got   = 1'b0;
            guard = 0;
            while (!got && guard < 100) begin
                @(negedge clk);
                cycles++;
                guard++;
                if (bus.o_mdata_accept) got = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!got) begin
                check("beat_accept_timeout", MDW'(got), 1);
                bus.i_mdata_valid = 1'b0;
                return;
            end
            model_beat(int'(start), bus.i_mdata, bus.i_mdata_byteen, bus.i_mdata_last);
            @(posedge clk);
            #1;
        end
        bus.i_mdata_valid = 1'b0;
        bus.i_mdata_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus.i_mdata_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_busy = 1'b0;
        m_pos  = 0;
        m_data = '0;
        m_be   = '0;
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       bus.i_mdata_accept = 1'b1;
            1:       bus.i_mdata_accept = ($urandom_range(0, 3) != 0);
            default: bus.i_mdata_accept = 1'b0;
        endcase
    end

    // Output monitor: handshake rule, stability under backpressure, scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic [MDW-1:0] mask;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            check("accept_comb", MDW'(bus.o_mdata_accept),
                  MDW'(!bus.o_mdata_valid || bus.i_mdata_accept));
            if (hold) begin
                check("hold_valid", MDW'(bus.o_mdata_valid), 1);
                check("hold_data", bus.o_mdata, h_data);
                check("hold_byteen", MDW'(bus.o_mdata_byteen), MDW'(h_be));
                check("hold_last", MDW'(bus.o_mdata_last), MDW'(h_last));
            end
            if (bus.o_mdata_valid && bus.i_mdata_accept) begin
                check("out_expected", MDW'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    mask = unit_mask(e.be);
                    check("out_byteen", MDW'(bus.o_mdata_byteen), MDW'(e.be));
                    check("out_last", MDW'(bus.o_mdata_last), MDW'(e.last));
`ifdef PZCOREBUS_UPSIZER_PACKER_ZERO_FILL_EN
                    check("out_data_zf", bus.o_mdata, e.data & mask);
`else
                    check("out_data", bus.o_mdata & mask, e.data & mask);
`endif
                end
            end
            hold   = bus.o_mdata_valid && !bus.i_mdata_accept;
            h_data = bus.o_mdata;
            h_be   = bus.o_mdata_byteen;
            h_last = bus.o_mdata_last;
        end
    end

    initial begin
        int cyc;
        int total;
        int guard;
        hold = 1'b0;
        m_busy = 1'b0;
        m_pos  = 0;
        m_data = '0;
        m_be   = '0;
        bus.i_start_index  = '0;
        bus.i_mdata_valid  = 1'b0;
        bus.i_mdata        = '0;
        bus.i_mdata_byteen = '0;
        bus.i_mdata_last   = 1'b0;
        bus.i_mdata_accept = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", MDW'(bus.o_mdata_valid), 0);
        check("rst_last", MDW'(bus.o_mdata_last), 0);
        check("rst_data", bus.o_mdata, 0);
        check("rst_byteen", MDW'(bus.o_mdata_byteen), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full word from slot 0, one cycle latency.
        send_burst(4'd0, 4, 1, 1'b1, cyc);
        check("t1_cycles", MDW'(cyc), 4);
        @(negedge clk);
        check("t1_valid", MDW'(bus.o_mdata_valid), 1);
        check("t1_data", bus.o_mdata, {beat_data[3], beat_data[2], beat_data[1], beat_data[0]});
        check("t1_byteen", MDW'(bus.o_mdata_byteen), 16'hFFFF);
        check("t1_last", MDW'(bus.o_mdata_last), 1);

        // Partial words mid-word.
        @(posedge clk);
        #1;
        send_burst(4'd4, 2, 1, 1'b1, cyc);
        @(negedge clk);
        check("t2_byteen", MDW'(bus.o_mdata_byteen), 16'h0FF0);
        check("t2_data_b", MDW'(bus.o_mdata[95:64]), MDW'(beat_data[1]));
        check("t2_data_a", MDW'(bus.o_mdata[63:32]), MDW'(beat_data[0]));
        check("t2_last", MDW'(bus.o_mdata_last), 1);
`ifdef PZCOREBUS_UPSIZER_PACKER_ZERO_FILL_EN
        check("t6_zero_hi", MDW'(bus.o_mdata[127:96]), 0);
        check("t6_zero_lo", MDW'(bus.o_mdata[31:0]), 0);
`endif
        @(posedge clk);
        #1;
        send_burst(4'd9, 2, 1, 1'b1, cyc);
        @(negedge clk);
        check("t2b_byteen", MDW'(bus.o_mdata_byteen), 16'hFF00);
        check("t2b_data", MDW'(bus.o_mdata[127:64]), MDW'({beat_data[1], beat_data[0]}));

        // Wrap across a word boundary.
        @(posedge clk);
        #1;
        send_burst(4'd12, 3, 1, 1'b1, cyc);
        @(negedge clk);
        check("t3_byteen", MDW'(bus.o_mdata_byteen), 16'h00FF);
        check("t3_data", MDW'(bus.o_mdata[63:0]), MDW'({beat_data[2], beat_data[1]}));
        check("t3_last", MDW'(bus.o_mdata_last), 1);

        // Backpressure with a full word pending, then streaming without bubbles.
        @(posedge clk);
        #1;
        bp_mode = 2;
        send_burst(4'd0, 4, 0, 1'b1, cyc);
        repeat (5) begin
            @(negedge clk);
            check("t4_stall_accept", MDW'(bus.o_mdata_accept), 0);
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        send_burst(4'd0, 8, 0, 1'b1, cyc);
        check("t4_stream_cycles", MDW'(cyc), 8);
        total = 0;
        for (int i = 0; i < 6; i++) begin
            send_burst(IW'($urandom), 1, 0, 1'b1, cyc);
            total += cyc;
        end
        check("t4_single_beats", MDW'(total), 6);

        // All-zero enables still advance the slot and flush.
        send_burst(4'd12, 2, 2, 1'b1, cyc);
        @(negedge clk);
        check("zero_be_byteen", MDW'(bus.o_mdata_byteen), 0);
        check("zero_be_last", MDW'(bus.o_mdata_last), 1);

        // Reset mid-burst drops partial data.
        @(posedge clk);
        #1;
        send_burst(4'd0, 2, 1, 1'b0, cyc);
        pulse_reset();
        @(negedge clk);
        check("t5_valid_after_rst", MDW'(bus.o_mdata_valid), 0);
        @(posedge clk);
        #1;
        send_burst(4'd4, 4, 1, 1'b1, cyc);

        // Randomized bursts under random backpressure.
        bp_mode = 1;
        for (int b = 0; b < 40; b++) begin
            send_burst(IW'($urandom), int'($urandom_range(1, 9)), int'($urandom_range(0, 1)),
                       1'b1, cyc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        bp_mode = 0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain_empty", MDW'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
